// File: rtl/gen_frec.sv
// NCO-based square-wave / pulse-burst generator.
// Output frequency is f_clock * step / 2^ACC_WIDTH; burst_len=0 runs continuously.
module gen_frec #(
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] step,
  input  logic [CNT_WIDTH-1:0] burst_len,
  output logic                 clock_o,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pulse_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ACC_WIDTH-1:0] STEP_MAX =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] step_l;
  logic [CNT_WIDTH-1:0] len_l;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 msb;
  logic                 last_fall;

  assign acc_nxt = acc + step_l;
  assign msb     = acc_nxt[ACC_WIDTH-1];

  // Burst ends on the falling edge that follows the final counted rise,
  // so the last pulse always has its full high time.
  assign last_fall = (len_l != '0) && (pulse_count == len_l)
                   && clock_o && !msb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      step_l      <= '0;
      len_l       <= '0;
      clock_o     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          acc     <= '0;
          clock_o <= 1'b0;
          busy    <= 1'b0;
          if (start && enable) begin
            // Clamp to f_clock/2 so the output never aliases.
            step_l      <= (step > STEP_MAX) ? STEP_MAX : step;
            len_l       <= burst_len;
            pulse_count <= '0;
            state       <= RUN;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            clock_o <= 1'b0;
          end else if (last_fall) begin
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            clock_o <= 1'b0;
            done    <= 1'b1;
          end else begin
            acc     <= acc_nxt;
            clock_o <= msb;
            if (!clock_o && msb)
              pulse_count <= pulse_count + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_frec.sv
// Directed bench for gen_frec: expected outputs queued per edge,
// popped and checked 1 time unit after each rising clock edge.
module tb_gen_frec;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [31:0] step;
  logic [31:0] burst_len;
  logic        clock_o;
  logic        busy;
  logic        done;
  logic [31:0] pulse_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        co;
    logic        bz;
    logic        dn;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  gen_frec #(.ACC_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .start(start),
    .step(step),
    .burst_len(burst_len),
    .clock_o(clock_o),
    .busy(busy),
    .done(done),
    .pulse_count(pulse_count)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic co,
                      input logic bz, input logic dn,
                      input logic [31:0] pc);
    exp_t e;
    e.tag = tag;
    e.co  = co;
    e.bz  = bz;
    e.dn  = dn;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [34:0] act;
    logic [34:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e   = sb.pop_front();
      act = {clock_o, busy, done, pulse_count};
      exp = {e.co, e.bz, e.dn, e.pc};
      assert (act === exp) else begin
        errors++;
        $error("FAIL %s: observed co/busy/done/cnt=%b/%b/%b/%0d expected %b/%b/%b/%0d",
               e.tag, clock_o, busy, done, pulse_count,
               e.co, e.bz, e.dn, e.pc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_now();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    start     = 1'b0;
    step      = '0;
    burst_len = '0;
    #2;
    push("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    check_now();
    reset = 1'b0;
    enable = 1'b1;
    push("idle", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    // continuous, period 4
    step = 32'h4000_0000; burst_len = 0; start = 1'b1;
    push("cont_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      push($sformatf("cont_e%0d", e), (e % 4 >= 2), 1'b1, 1'b0,
           32'((e + 2) / 4));
      tick();
    end
    enable = 1'b0;
    push("cont_abort", 1'b0, 1'b0, 1'b0, 32'd5);
    tick();
    enable = 1'b1;

    // burst of 3
    step = 32'h4000_0000; burst_len = 3; start = 1'b1;
    push("b3_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      push($sformatf("b3_e%0d", e), (e % 4 >= 2), 1'b1, 1'b0,
           32'((e + 2) / 4));
      tick();
    end
    push("b3_done", 1'b0, 1'b0, 1'b1, 32'd3);
    tick();
    push("b3_done_clr", 1'b0, 1'b0, 1'b0, 32'd3);
    tick();
    push("b3_hold", 1'b0, 1'b0, 1'b0, 32'd3);
    tick();

    // saturated step, burst of 4
    step = 32'hFFFF_FFFF; burst_len = 4; start = 1'b1;
    push("sat_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      push($sformatf("sat_e%0d", e), (e % 2 == 1), 1'b1, 1'b0,
           32'((e + 1) / 2));
      tick();
    end
    push("sat_done", 1'b0, 1'b0, 1'b1, 32'd4);
    tick();
    push("sat_done_clr", 1'b0, 1'b0, 1'b0, 32'd4);
    tick();

    // abort mid-burst via enable
    step = 32'h4000_0000; burst_len = 10; start = 1'b1;
    push("ab_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      push($sformatf("ab_e%0d", e), (e % 4 >= 2), 1'b1, 1'b0,
           32'((e + 2) / 4));
      tick();
    end
    enable = 1'b0;
    push("ab_idle", 1'b0, 1'b0, 1'b0, 32'd2);
    tick();
    start = 1'b1;
    for (int e = 0; e < 2; e++) begin
      push("ab_start_noen", 1'b0, 1'b0, 1'b0, 32'd2);
      tick();
    end
    start = 1'b0;
    enable = 1'b1;
    push("ab_hold", 1'b0, 1'b0, 1'b0, 32'd2);
    tick();

    // inputs changed and start re-pulsed during RUN
    step = 32'h4000_0000; burst_len = 3; start = 1'b1;
    push("frz_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    step = 32'h8000_0000; burst_len = 1;
    for (int e = 1; e <= 11; e++) begin
      push($sformatf("frz_e%0d", e), (e % 4 >= 2), 1'b1, 1'b0,
           32'((e + 2) / 4));
      tick();
    end
    start = 1'b0;
    push("frz_done", 1'b0, 1'b0, 1'b1, 32'd3);
    tick();

    // step = 0 never pulses
    step = 32'd0; burst_len = 1; start = 1'b1;
    push("z_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      push("z_run", 1'b0, 1'b1, 1'b0, 32'd0);
      tick();
    end
    enable = 1'b0;
    push("z_abort", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    enable = 1'b1;

    // async reset mid-burst
    step = 32'h4000_0000; burst_len = 10; start = 1'b1;
    push("rs_start", 1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    start = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      push($sformatf("rs_e%0d", e), (e % 4 >= 2), 1'b1, 1'b0,
           32'((e + 2) / 4));
      tick();
    end
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    push("rs_async", 1'b0, 1'b0, 1'b0, 32'd0);
    check_now();
    push("rs_start_ign", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    push("rs_release", 1'b0, 1'b0, 1'b0, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
